// File: rtl/shift_pkg.sv
// Shared types for the sequential shift unit: opcodes, FSM states and the
// per-pass carry-out rule.
package shift_pkg;

  typedef enum logic [1:0] {SH_LSL, SH_LSR, SH_ASR, SH_ROR} shop_t;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} shst_t;

  localparam int MAX_STEP = 3;

  // Bit that leaves the operand in one pass; rotates report the bit landing in bit 7.
  function automatic logic pass_carry(input shop_t op, input logic [7:0] acc,
                                      input logic [7:0] res, input logic [1:0] step);
    logic c;
    c = 1'b0;
    case (op)
      SH_LSL: begin
        case (step)
          2'd1:    c = acc[7];
          2'd2:    c = acc[6];
          2'd3:    c = acc[5];
          default: c = 1'b0;
        endcase
      end
      SH_LSR, SH_ASR: begin
        case (step)
          2'd1:    c = acc[0];
          2'd2:    c = acc[1];
          2'd3:    c = acc[2];
          default: c = 1'b0;
        endcase
      end
      SH_ROR:  c = res[7];
      default: c = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/shift_seq_ctrl_shifter8.sv
// Combinational 8-bit shifter producing all four shift flavours for an
// amount of 0..3; the caller picks the one it needs.
module shifter8 (
  input  logic [7:0] i_a,
  input  logic [1:0] i_amt,
  output logic [7:0] o_lsl,
  output logic [7:0] o_lsr,
  output logic [7:0] o_asr,
  output logic [7:0] o_ror
);

  logic [15:0] w_rorWide;

  assign w_rorWide = {i_a, i_a} >> i_amt;

  assign o_lsl = i_a << i_amt;
  assign o_lsr = i_a >> i_amt;
  assign o_asr = 8'($signed(i_a) >>> i_amt);
  assign o_ror = w_rorWide[7:0];

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift/rotate unit: breaks a wide amount into passes of at most
// three bits through shifter8 and returns data, carry and zero by handshake.
module shift_seq_ctrl
  import shift_pkg::*;
#(
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  shop_t            in_op,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_carry,
  output logic             out_zero,
  output logic             busy
);

  shst_t            r_state;
  shop_t            r_op;
  logic [7:0]       r_acc;
  logic [AMT_W-1:0] r_rem;
  logic             r_outValid;
  logic [7:0]       r_outData;
  logic             r_outCarry;
  logic             r_outZero;

  logic [1:0]       w_step;
  logic [AMT_W-1:0] w_remNext;
  logic [7:0]       w_lsl;
  logic [7:0]       w_lsr;
  logic [7:0]       w_asr;
  logic [7:0]       w_ror;
  logic [7:0]       w_shifted;
  logic             w_passCarry;

  assign w_step    = (r_rem > AMT_W'(MAX_STEP)) ? 2'(MAX_STEP) : r_rem[1:0];
  assign w_remNext = r_rem - AMT_W'(w_step);

  shifter8 u_shifter (
    .i_a   (r_acc),
    .i_amt (w_step),
    .o_lsl (w_lsl),
    .o_lsr (w_lsr),
    .o_asr (w_asr),
    .o_ror (w_ror)
  );

  always_comb begin
    w_shifted = w_lsl;
    case (r_op)
      SH_LSL:  w_shifted = w_lsl;
      SH_LSR:  w_shifted = w_lsr;
      SH_ASR:  w_shifted = w_asr;
      SH_ROR:  w_shifted = w_ror;
      default: w_shifted = w_lsl;
    endcase
  end

  assign w_passCarry = pass_carry(r_op, r_acc, w_shifted, w_step);

  // Output registers are loaded only on entry to DONE so they never show partial passes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_op       <= SH_LSL;
      r_acc      <= 8'h00;
      r_rem      <= '0;
      r_outValid <= 1'b0;
      r_outData  <= 8'h00;
      r_outCarry <= 1'b0;
      r_outZero  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_op  <= in_op;
            r_acc <= in_data;
            r_rem <= in_amt;
            if (in_amt == '0) begin
              r_state    <= ST_DONE;
              r_outValid <= 1'b1;
              r_outData  <= in_data;
              r_outCarry <= 1'b0;
              r_outZero  <= (in_data == 8'h00);
            end else begin
              r_state <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          r_acc <= w_shifted;
          r_rem <= w_remNext;
          if (w_remNext == '0) begin
            r_state    <= ST_DONE;
            r_outValid <= 1'b1;
            r_outData  <= w_shifted;
            r_outCarry <= w_passCarry;
            r_outZero  <= (w_shifted == 8'h00);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state    <= ST_IDLE;
            r_outValid <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign out_valid = r_outValid;
  assign out_data  = r_outData;
  assign out_carry = r_outCarry;
  assign out_zero  = r_outZero;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl: hand-computed results, pass latency,
// output hold under backpressure and reset abort.
module tb_shift_seq_ctrl;
  import shift_pkg::*;

  localparam int AMT_W = 4;
  localparam int MAX_WAIT = 40;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  shop_t            in_op;
  logic [AMT_W-1:0] in_amt;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic             out_carry;
  logic             out_zero;
  logic             busy;

  int checks = 0;
  int errors = 0;

  shift_seq_ctrl #(.AMT_W(AMT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_op     (in_op),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry),
    .out_zero  (out_zero),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic nextEdge();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for exactly one accepting edge.
  task automatic applyStimulus(input logic [7:0] data, input shop_t op, input logic [AMT_W-1:0] amt);
    in_valid = 1'b1;
    in_data  = data;
    in_op    = op;
    in_amt   = amt;
    nextEdge();
    in_valid = 1'b0;
  endtask

  task automatic waitResult(output int edges);
    edges = 0;
    while (!out_valid && edges < MAX_WAIT) begin
      nextEdge();
      edges++;
    end
  endtask

  task automatic runOp(input string tag, input logic [7:0] data, input shop_t op,
                       input logic [AMT_W-1:0] amt, input logic [7:0] expData,
                       input logic expC, input logic expZ, input int expEdges);
    int edges;
    applyStimulus(data, op, amt);
    waitResult(edges);
    checkOutput({tag, " latency"}, edges, expEdges);
    checkOutput({tag, " valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, " data"}, 32'(out_data), 32'(expData));
    checkOutput({tag, " carry"}, 32'(out_carry), 32'(expC));
    checkOutput({tag, " zero"}, 32'(out_zero), 32'(expZ));
    out_ready = 1'b1;
    nextEdge();
    out_ready = 1'b0;
    checkOutput({tag, " in_ready after handshake"}, 32'(in_ready), 32'd1);
    checkOutput({tag, " valid dropped"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int edges;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_op     = SH_LSL;
    in_amt    = '0;
    out_ready = 1'b0;

    nextEdge();
    nextEdge();
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset out_data", 32'(out_data), 32'd0);
    checkOutput("reset carry", 32'(out_carry), 32'd0);
    checkOutput("reset zero", 32'(out_zero), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    nextEdge();

    runOp("lsl81x1", 8'h81, SH_LSL, 4'd1, 8'h02, 1'b1, 1'b0, 1);
    runOp("asr90x7", 8'h90, SH_ASR, 4'd7, 8'hFF, 1'b0, 1'b0, 3);
    runOp("ror01x9", 8'h01, SH_ROR, 4'd9, 8'h80, 1'b1, 1'b0, 3);
    runOp("rorA5x8", 8'hA5, SH_ROR, 4'd8, 8'hA5, 1'b1, 1'b0, 3);

    // Zero amount, then backpressure with an ignored second request.
    applyStimulus(8'hF0, SH_LSR, 4'd0);
    checkOutput("lsrF0x0 valid", 32'(out_valid), 32'd1);
    checkOutput("lsrF0x0 data", 32'(out_data), 32'hF0);
    checkOutput("lsrF0x0 carry", 32'(out_carry), 32'd0);
    checkOutput("lsrF0x0 zero", 32'(out_zero), 32'd0);
    in_valid = 1'b1;
    in_data  = 8'h3C;
    in_op    = SH_LSL;
    in_amt   = 4'd2;
    for (int i = 0; i < 5; i++) begin
      nextEdge();
      checkOutput("hold data", 32'(out_data), 32'hF0);
      checkOutput("hold valid", 32'(out_valid), 32'd1);
      checkOutput("hold in_ready", 32'(in_ready), 32'd0);
      checkOutput("hold busy", 32'(busy), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    nextEdge();
    out_ready = 1'b0;
    checkOutput("hold release in_ready", 32'(in_ready), 32'd1);
    nextEdge();
    checkOutput("ignored request no valid", 32'(out_valid), 32'd0);
    checkOutput("ignored request idle", 32'(busy), 32'd0);

    runOp("lsl01x8", 8'h01, SH_LSL, 4'd8, 8'h00, 1'b1, 1'b1, 3);
    runOp("lsl01x9", 8'h01, SH_LSL, 4'd9, 8'h00, 1'b0, 1'b1, 3);
    runOp("lsrF0x3", 8'hF0, SH_LSR, 4'd3, 8'h1E, 1'b0, 1'b0, 1);

    // Abort a long arithmetic shift with reset part-way through.
    applyStimulus(8'h80, SH_ASR, 4'd15);
    nextEdge();
    checkOutput("abort busy before reset", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort in_ready", 32'(in_ready), 32'd1);
    checkOutput("abort out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort out_data", 32'(out_data), 32'd0);
    checkOutput("abort busy", 32'(busy), 32'd0);
    nextEdge();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      nextEdge();
      checkOutput("post-abort no valid", 32'(out_valid), 32'd0);
    end

    runOp("asr80x15", 8'h80, SH_ASR, 4'd15, 8'hFF, 1'b1, 1'b0, 5);

    waitResult(edges);
    checkOutput("final idle no result", edges, MAX_WAIT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
